// File: rtl/ysyx_22050078_mem_arbiter.sv
// ysyx_22050078_mem_arbiter
//
// Shares the single physical-memory port between the instruction-fetch path (IFU) and the
// load/store path (LSU). Only one transaction is in flight at a time. It moves through
// IDLE -> ISSUE -> WAIT -> RESP. The response goes back to whichever requester was granted.
//
// Configuration macro: ARB_RR_EN
//   defined   : round-robin arbitration. A last-grant register picks the requester that was
//               not granted last time.
//   undefined : fixed priority, LSU over IFU.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   if_req_*            IFU read request (valid/ready/addr)
//   if_rsp_*            IFU response (one-cycle valid pulse, data held until next RESP)
//   ls_req_*            LSU request (valid/ready/addr/wen/wdata/wmask)
//   ls_rsp_*            LSU response (one-cycle valid pulse, data held until next RESP)
//   mem_req_*           request to memory, fields latched at accept
//   mem_rsp_*           response from memory, only observed in WAIT
//   busy_o              high whenever the FSM is not idle
module ysyx_22050078_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rsp_data_o,

    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_req_addr_i,
    input  logic                ls_req_wen_i,
    input  logic [DATA_W-1:0]   ls_req_wdata_i,
    input  logic [DATA_W/8-1:0] ls_req_wmask_i,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   ls_rsp_data_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_wen_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,

    output logic                busy_o
);

    localparam int unsigned MaskW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_ls_q, owner_ls_d;   // 1: LSU owns the transaction
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MaskW-1:0]    wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                idle;
    logic                grant_ls;
    logic                accept;

`ifdef ARB_RR_EN
    logic                last_ls_q, last_ls_d;    // 1: last accept went to LSU
`endif

    assign idle = (state_q == StIdle);

    // grant_ls only matters while idle; IFU wins whenever LSU does not.
`ifdef ARB_RR_EN
    assign grant_ls = ls_req_valid_i && (!if_req_valid_i || !last_ls_q);
`else
    assign grant_ls = ls_req_valid_i;
`endif

    assign ls_req_ready_o = idle && grant_ls;
    assign if_req_ready_o = idle && if_req_valid_i && !grant_ls;
    assign accept         = ls_req_ready_o || if_req_ready_o;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
`ifdef ARB_RR_EN
        last_ls_d  = last_ls_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StIssue;
                    owner_ls_d = grant_ls;
`ifdef ARB_RR_EN
                    last_ls_d  = grant_ls;
`endif
                    if (grant_ls) begin
                        addr_d  = ls_req_addr_i;
                        wen_d   = ls_req_wen_i;
                        wdata_d = ls_req_wdata_i;
                        wmask_d = ls_req_wmask_i;
                    end else begin
                        // Instruction fetches are always plain reads.
                        addr_d  = if_req_addr_i;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            StIssue: begin
                if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid_i) begin
                    rdata_d = mem_rsp_data_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`endif

    assign mem_req_valid_o = (state_q == StIssue);
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wen_o   = wen_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wmask_o = wmask_q;

    assign if_rsp_valid_o  = (state_q == StResp) && !owner_ls_q;
    assign ls_rsp_valid_o  = (state_q == StResp) && owner_ls_q;
    assign if_rsp_data_o   = rdata_q;
    assign ls_rsp_data_o   = rdata_q;

    assign busy_o          = !idle;

endmodule

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// Self-checking bench for ysyx_22050078_mem_arbiter. The bench plays both requesters and the
// memory. A transaction-level model predicts each grant (fixed or round-robin per ARB_RR_EN),
// the memory request fields and the routed response.
module tb_ysyx_22050078_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [7:0]  ls_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, busy;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [7:0]  mem_req_wmask;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          last_ls  = 1'b0;   // model: most recent grant went to LSU

    always #5 clk = ~clk;

    ysyx_22050078_mem_arbiter #(
        .ADDR_W (64),
        .DATA_W (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req_valid_i  (if_req_valid),
        .if_req_ready_o  (if_req_ready),
        .if_req_addr_i   (if_req_addr),
        .if_rsp_valid_o  (if_rsp_valid),
        .if_rsp_data_o   (if_rsp_data),
        .ls_req_valid_i  (ls_req_valid),
        .ls_req_ready_o  (ls_req_ready),
        .ls_req_addr_i   (ls_req_addr),
        .ls_req_wen_i    (ls_req_wen),
        .ls_req_wdata_i  (ls_req_wdata),
        .ls_req_wmask_i  (ls_req_wmask),
        .ls_rsp_valid_o  (ls_rsp_valid),
        .ls_rsp_data_o   (ls_rsp_data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_wen_o   (mem_req_wen),
        .mem_req_wdata_o (mem_req_wdata),
        .mem_req_wmask_o (mem_req_wmask),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .busy_o          (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_grant_ls(input bit iv, input bit lv);
        bit g;
        if (!lv) begin
            g = 1'b0;
        end else if (!iv) begin
            g = 1'b1;
        end else begin
`ifdef ARB_RR_EN
            g = !last_ls;
`else
            g = 1'b1;
`endif
        end
        return g;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_no_rsp(input string tag);
        check_eq({tag, ".if_rsp_valid"}, {63'd0, if_rsp_valid}, 64'd0);
        check_eq({tag, ".ls_rsp_valid"}, {63'd0, ls_rsp_valid}, 64'd0);
    endtask

    task automatic check_no_ready(input string tag);
        check_eq({tag, ".if_req_ready"}, {63'd0, if_req_ready}, 64'd0);
        check_eq({tag, ".ls_req_ready"}, {63'd0, ls_req_ready}, 64'd0);
    endtask

    // One complete transaction. The loser (if any) keeps its valid asserted throughout,
    // so the ready outputs are checked against a pending request while busy.
    // rdly: cycles of mem_req_ready=0 before acceptance; wdly: idle WAIT cycles before the
    // response; spur: spurious mem_rsp_valid during the first ISSUE cycle.
    task automatic run_txn(input bit iv, input bit lv, input logic [63:0] ia,
                           input logic [63:0] la, input bit lw, input logic [63:0] lwd,
                           input logic [7:0] lm, input int rdly, input int wdly,
                           input logic [63:0] rdata, input bit spur);
        bit          gl;
        logic [63:0] exp_addr;
        logic        exp_wen;
        logic [7:0]  exp_mask;
        if_req_valid  = iv;
        if_req_addr   = ia;
        ls_req_valid  = lv;
        ls_req_addr   = la;
        ls_req_wen    = lw;
        ls_req_wdata  = lwd;
        ls_req_wmask  = lm;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        gl       = model_grant_ls(iv, lv);
        exp_addr = gl ? la : ia;
        exp_wen  = gl ? lw : 1'b0;
        exp_mask = gl ? lm : 8'h00;

        @(negedge clk);
        check_eq("idle.busy", {63'd0, busy}, 64'd0);
        check_eq("idle.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check_eq("grant.if_req_ready", {63'd0, if_req_ready}, {63'd0, iv && !gl});
        check_eq("grant.ls_req_ready", {63'd0, ls_req_ready}, {63'd0, gl});
        next_cycle();
        last_ls = gl;
        if (gl) ls_req_valid = 1'b0;
        else    if_req_valid = 1'b0;

        for (int d = 0; d <= rdly; d++) begin
            mem_req_ready = (d == rdly);
            mem_rsp_valid = spur && (d == 0);
            mem_rsp_data  = rand64();
            @(negedge clk);
            check_eq("issue.mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
            check_eq("issue.mem_req_addr", mem_req_addr, exp_addr);
            check_eq("issue.mem_req_wen", {63'd0, mem_req_wen}, {63'd0, exp_wen});
            check_eq("issue.mem_req_wmask", {56'd0, mem_req_wmask}, {56'd0, exp_mask});
            if (gl) check_eq("issue.mem_req_wdata", mem_req_wdata, lwd);
            check_eq("issue.busy", {63'd0, busy}, 64'd1);
            check_no_ready("issue");
            check_no_rsp("issue");
            next_cycle();
        end
        mem_req_ready = 1'b0;

        for (int d = 0; d <= wdly; d++) begin
            mem_rsp_valid = (d == wdly);
            mem_rsp_data  = (d == wdly) ? rdata : rand64();
            @(negedge clk);
            check_eq("wait.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
            check_eq("wait.busy", {63'd0, busy}, 64'd1);
            check_no_ready("wait");
            check_no_rsp("wait");
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = rand64();

        @(negedge clk);
        check_eq("resp.if_rsp_valid", {63'd0, if_rsp_valid}, {63'd0, !gl});
        check_eq("resp.ls_rsp_valid", {63'd0, ls_rsp_valid}, {63'd0, gl});
        if (gl) check_eq("resp.ls_rsp_data", ls_rsp_data, rdata);
        else    check_eq("resp.if_rsp_data", if_rsp_data, rdata);
        check_eq("resp.busy", {63'd0, busy}, 64'd1);
        check_no_ready("resp");
        next_cycle();

        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        check_eq("after.busy", {63'd0, busy}, 64'd0);
        check_no_rsp("after");
        if (gl) check_eq("after.ls_rsp_data_hold", ls_rsp_data, rdata);
        else    check_eq("after.if_rsp_data_hold", if_rsp_data, rdata);
        next_cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        ls_req_valid  = 1'b0;
        ls_req_addr   = '0;
        ls_req_wen    = 1'b0;
        ls_req_wdata  = '0;
        ls_req_wmask  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("reset.busy", {63'd0, busy}, 64'd0);
        check_eq("reset.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check_eq("reset.mem_req_addr", mem_req_addr, 64'd0);
        check_eq("reset.mem_req_wdata", mem_req_wdata, 64'd0);
        check_eq("reset.if_rsp_data", if_rsp_data, 64'd0);
        check_eq("reset.ls_rsp_data", ls_rsp_data, 64'd0);
        check_no_rsp("reset");
        rst_n = 1'b1;
        next_cycle();

        // Single IFU read, ready immediately, response two cycles after ready.
        run_txn(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd0, 1'b0, 64'd0, 8'h00,
                0, 1, 64'h0000_0000_0010_0093, 1'b0);
        // LSU write with memory stalling for three cycles.
        run_txn(1'b0, 1'b1, 64'd0, 64'h0000_0000_8000_1000, 1'b1, 64'hDEAD_BEEF_0000_0001,
                8'h0F, 3, 0, rand64(), 1'b0);
        // Simultaneous requests, four rounds.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 64'h8000_0000 + 64'(4 * i), 64'h8000_2000 + 64'(8 * i),
                    1'b0, 64'd0, 8'h00, 1, 1, rand64(), 1'b0);
        end
        // Spurious response during ISSUE must be ignored.
        run_txn(1'b1, 1'b0, 64'h8000_0100, 64'd0, 1'b0, 64'd0, 8'h00, 2, 0, rand64(), 1'b1);

        // Reset while in WAIT.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0200;
        next_cycle();                 // accepted -> ISSUE
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();                 // -> WAIT
        mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid.busy", {63'd0, busy}, 64'd0);
        check_eq("rst_mid.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check_eq("rst_mid.mem_req_addr", mem_req_addr, 64'd0);
        check_no_rsp("rst_mid");
        check_no_ready("rst_mid");
        last_ls = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rand64();
        @(negedge clk);
        check_no_rsp("late_rsp0");
        next_cycle();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_no_rsp("late_rsp1");
        check_eq("late_rsp.busy", {63'd0, busy}, 64'd0);
        next_cycle();
        run_txn(1'b1, 1'b0, 64'h8000_0300, 64'd0, 1'b0, 64'd0, 8'h00, 0, 0, rand64(), 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit iv, lv;
            iv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            if (!iv && !lv) iv = 1'b1;
            run_txn(iv, lv, rand64(), rand64(), 1'($urandom_range(0, 1)), rand64(),
                    8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    rand64(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050078_mem_arbiter.md
# ysyx_22050078_mem_arbiter

Shares the single physical-memory port between the instruction-fetch path (IFU) and the load/store path (LSU). It arbitrates between the two requesters, issues one transaction at a time to memory over a valid/ready request channel and returns the response to the winning requester. It sits between IFU/LSU and the memory/DPI bridge.

## Interface
- ADDR_W, 64, address width (matches CPU_WIDTH)
- DATA_W, 64, data width; write mask width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IFU read request
- if_req_ready  out  1  IFU request accepted this cycle
- if_req_addr  in  ADDR_W  IFU fetch address (pc)
- if_rsp_valid  out  1  one-cycle pulse, IFU read data valid
- if_rsp_data  out  DATA_W  IFU read data
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_req_addr  in  ADDR_W  LSU address
- ls_req_wen  in  1  1 = write, 0 = read
- ls_req_wdata  in  DATA_W  write data
- ls_req_wmask  in  DATA_W/8  byte write mask
- ls_rsp_valid  out  1  one-cycle pulse, LSU read data / write ack
- ls_rsp_data  out  DATA_W  LSU read data (memory return data on writes)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_W  memory response data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. Single outstanding transaction.
- IDLE: arbitrate among asserted req_valids; drive winner's req_ready=1 combinationally, loser's 0. On valid&&ready latch addr/wen/wdata/wmask and owner (IF or LS) -> ISSUE. IFU requests latched with wen=0, wmask=0.
- ISSUE: mem_req_valid=1 with latched fields, stable until mem_req_ready=1 -> WAIT.
- WAIT: on mem_rsp_valid=1 latch mem_rsp_data -> RESP. mem_rsp_valid outside WAIT ignored.
- RESP: owner's rsp_valid=1 for exactly one cycle, rsp_data = latched data -> IDLE. Non-owner rsp_valid stays 0.
- Arbitration (default, fixed priority): LSU wins when both valid.
- Both req_ready are 0 in every non-IDLE state; requesters hold valid and fields stable until ready.
- rsp_data outputs hold last latched value until next RESP.

## Timing
- Reset: state=IDLE; mem_req_valid, if_rsp_valid, ls_rsp_valid, busy = 0; all latched address/data/mask registers and rsp_data = 0; last-grant register = IF.
- Accept at cycle N -> mem_req_valid=1 at N+1. mem_req_ready at cycle K -> WAIT from K+1. mem_rsp_valid at cycle M -> rsp_valid=1 at M+1 -> IDLE at M+2, new accept possible at M+2.
- Minimum turnaround (ready at N+1, rsp at N+2): 4 cycles accept-to-accept.
- Reset asserted mid-transaction: immediate return to reset values; in-flight response discarded, no rsp_valid.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted last; last-grant register updates on every accept. Single requester always wins.
- ARB_RR_EN undefined: fixed priority LSU > IFU; last-grant register absent.

## Test plan
- Single IFU read addr 0x8000_0000, mem_req_ready immediate, mem_rsp_data 0x0000_0000_0010_0093 two cycles later -> if_rsp_valid one cycle with that data, ls_rsp_valid 0, busy falls after RESP.
- LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF_0000_0001, wmask 0x0F, mem_req_ready held 0 for 3 cycles -> mem_req_* stable all 3 cycles, ls_rsp_valid pulse after mem_rsp_valid.
- IFU and LSU valid same cycle, repeated 4 times -> fixed: LSU granted 4 times; with ARB_RR_EN: grants LS, IF, LS, IF (last-grant reset = IF).
- Request arriving while busy -> both req_ready 0 until IDLE; mem_rsp_valid pulse during ISSUE ignored (no rsp_valid).
- rst_n asserted during WAIT -> all outputs 0 asynchronously; after release and late mem_rsp_valid, no rsp_valid; next IFU request completes normally.
